// File: rtl/fm_tx_controller.sv
// FM transmitter front-end: register bank, sample-rate tick, audio FIFO and
// carrier retune sequencer feeding the modulator datapath.
module fm_tx_controller #(
    parameter int A     = 8,
    parameter int N     = 18,
    parameter int L     = 2,
    parameter int K     = 4,
    parameter int DIV_W = 12,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [2:0]          wr_addr,
    input  logic [7:0]          wr_data,
    input  logic                s_valid,
    input  logic signed [A-1:0] s_data,
    output logic                s_ready,
    output logic signed [A-1:0] audio,
    output logic [N-1:0]        acc_inc,
    output logic [L-1:0]        df_inc_coef,
    output logic [K-1:0]        df_inc_fact,
    output logic                tx_en,
    output logic                busy,
    output logic                underrun
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RETUNE = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;

    logic [1:0]          state, state_nxt;
    logic                enable;
    logic [N-1:0]        target, target_nxt, commit_val, acc_nxt, ramp_val;
    logic [7:0]          freq_l, freq_m, step;
    logic [DIV_W-1:0]    div, div_nxt, cnt;
    logic [L-1:0]        dev_coef;
    logic [K-1:0]        dev_fact;
    logic                wr_ctrl, wr_div_l, wr_div_h, div_wr, commit, enable_rise;
    logic                tick, pop, push, flush, urun_set, reached;
    logic signed [A-1:0] audio_nxt;

    logic signed [A-1:0] mem [DEPTH];
    logic [AW:0]         wr_ptr, rd_ptr;
    logic                empty, full;

    // Returns {reached, next}; never steps past the target in either direction.
    function automatic logic [N:0] ramp(input logic [N-1:0] cur,
                                        input logic [N-1:0] tgt,
                                        input logic [7:0]   stp);
        logic [N-1:0] diff;
        logic [N-1:0] stp_n;
        stp_n = {{(N-8){1'b0}}, stp};
        diff  = (tgt >= cur) ? (tgt - cur) : (cur - tgt);
        if ((stp == 8'd0) || (diff <= stp_n)) return {1'b1, tgt};
        else if (tgt > cur)                   return {1'b0, cur + stp_n};
        else                                  return {1'b0, cur - stp_n};
    endfunction

    assign wr_ctrl     = wr_en && (wr_addr == 3'd0);
    assign wr_div_l    = wr_en && (wr_addr == 3'd5);
    assign wr_div_h    = wr_en && (wr_addr == 3'd6);
    assign commit      = wr_en && (wr_addr == 3'd3);
    assign div_wr      = wr_div_l || wr_div_h;
    assign enable_rise = wr_ctrl && wr_data[0] && !enable;
    assign commit_val  = {wr_data[N-17:0], freq_m, freq_l};
    assign target_nxt  = commit ? commit_val : target;
    assign tick        = enable && (cnt == '0);

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign s_ready = !full;
    assign push    = s_valid && s_ready;
    assign tx_en   = (state == S_RUN);
    assign busy    = (state == S_RETUNE);

    always_comb begin
        div_nxt = div;
        if (wr_div_l) div_nxt[7:0] = wr_data;
        if (wr_div_h) div_nxt[DIV_W-1:8] = wr_data[DIV_W-9:0];
    end

    always_comb begin
        state_nxt           = state;
        acc_nxt             = acc_inc;
        pop                 = 1'b0;
        urun_set            = 1'b0;
        {reached, ramp_val} = ramp(acc_inc, target_nxt, step);
        if (!enable) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   state_nxt = (acc_inc != target) ? S_RETUNE : S_RUN;
                S_RETUNE: if (tick) begin
                    acc_nxt = ramp_val;
                    if (reached) state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (commit && (commit_val != acc_inc)) state_nxt = S_RETUNE;
                    else if (tick) begin
                        if (!empty) pop = 1'b1;
                        else        urun_set = 1'b1;
                    end
                end
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    assign flush = (state != S_IDLE) && (state_nxt == S_IDLE);

    always_comb begin
        audio_nxt = audio;
        if (state_nxt != S_RUN)
            audio_nxt = '0;
        else if ((state == S_RUN) && tick)
            audio_nxt = pop ? mem[rd_ptr[AW-1:0]] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable      <= 1'b0;
            target      <= '0;
            freq_l      <= '0;
            freq_m      <= '0;
            step        <= '0;
            div         <= DIV_W'(1023);
            cnt         <= DIV_W'(1023);
            dev_coef    <= '0;
            dev_fact    <= '0;
            state       <= S_IDLE;
            acc_inc     <= '0;
            audio       <= '0;
            df_inc_coef <= '0;
            df_inc_fact <= '0;
            underrun    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            if (wr_ctrl)                      enable <= wr_data[0];
            if (wr_en && (wr_addr == 3'd1))   freq_l <= wr_data;
            if (wr_en && (wr_addr == 3'd2))   freq_m <= wr_data;
            if (wr_en && (wr_addr == 3'd7))   step   <= wr_data;
            if (wr_en && (wr_addr == 3'd4)) begin
                dev_coef <= wr_data[L-1:0];
                dev_fact <= wr_data[L+K-1:L];
            end
            target <= target_nxt;
            div    <= div_nxt;

            if (div_wr || enable_rise) cnt <= div_nxt;
            else if (enable)           cnt <= (cnt == '0) ? div : cnt - 1'b1;

            // Deviation settings only reach the modulator at sample boundaries.
            if (tick) begin
                df_inc_coef <= dev_coef;
                df_inc_fact <= dev_fact;
            end

            state   <= state_nxt;
            acc_inc <= acc_nxt;
            audio   <= audio_nxt;

            if (urun_set)                     underrun <= 1'b1;
            else if (wr_ctrl && wr_data[1])   underrun <= 1'b0;

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= s_data;
    end

endmodule

// File: tb/tb_fm_tx_controller.sv
// Scoreboard bench for fm_tx_controller: samples queued on push, checked on audio update.
module tb_fm_tx_controller;

    localparam int A = 8;
    localparam int N = 18;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_en;
    logic [2:0]   wr_addr;
    logic [7:0]   wr_data;
    logic         s_valid;
    logic [A-1:0] s_data;
    logic         s_ready;
    logic [A-1:0] audio;
    logic [N-1:0] acc_inc;
    logic [1:0]   df_inc_coef;
    logic [3:0]   df_inc_fact;
    logic         tx_en;
    logic         busy;
    logic         underrun;

    int           n_chk  = 0;
    int           n_pass = 0;
    int           cyc    = 0;
    logic [A-1:0] sb[$];

    fm_tx_controller dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .audio       (audio),
        .acc_inc     (acc_inc),
        .df_inc_coef (df_inc_coef),
        .df_inc_fact (df_inc_fact),
        .tx_en       (tx_en),
        .busy        (busy),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic clk_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic wr(input logic [2:0] addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        clk_wait(1);
        wr_en   = 1'b0;
    endtask

    task automatic push(input logic [A-1:0] v);
        s_valid = 1'b1;
        s_data  = v;
        clk_wait(1);
        s_valid = 1'b0;
    endtask

    task automatic push_sb(input logic [A-1:0] v);
        chk("push_ready", s_ready, 1);
        sb.push_back(v);
        push(v);
    endtask

    // Waits for the next audio update; reports elapsed cycles.
    task automatic wait_audio(output int n);
        logic [A-1:0] last;
        last = audio;
        n = 0;
        do begin
            clk_wait(1);
            n++;
        end while ((audio == last) && (n < 24));
        chk("audio_changed", 32'(audio != last), 1);
    endtask

    task automatic wait_acc(input logic [N-1:0] exp, input logic exp_busy);
        logic [N-1:0] last;
        int n;
        last = acc_inc;
        n = 0;
        do begin
            clk_wait(1);
            n++;
        end while ((acc_inc == last) && (n < 12));
        chk("ramp_acc", acc_inc, exp);
        chk("ramp_busy", busy, exp_busy);
        chk("ramp_audio", audio, 0);
    endtask

    task automatic expect_sample(output int t);
        int n;
        logic [A-1:0] exp;
        wait_audio(n);
        exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        chk("sb_audio", audio, exp);
        t = cyc;
    endtask

    // Wait so that the next write lands 'off' edges after a known tick edge.
    task automatic align(input int t, input int off);
        while (((cyc + 1 - t) % 4) != off) clk_wait(1);
    endtask

    initial begin
        int n, t, t2;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        clk_wait(1);

        chk("rst_audio", audio, 0);
        chk("rst_acc", acc_inc, 0);
        chk("rst_tx_en", tx_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_coef", df_inc_coef, 0);
        chk("rst_fact", df_inc_fact, 0);
        chk("rst_s_ready", s_ready, 1);

        // Idle fill: FIFO accepts but never drains while disabled.
        wr(3'd5, 8'd3);
        wr(3'd6, 8'd0);
        for (int i = 1; i <= 4; i++) push_sb(8'(i * 16));
        chk("full_s_ready", s_ready, 0);
        clk_wait(8);
        chk("idle_no_pop", s_ready, 0);
        chk("idle_tx_en", tx_en, 0);

        // Immediate tune with STEP=0.
        wr(3'd7, 8'h00);
        wr(3'd1, 8'h00);
        wr(3'd2, 8'h10);
        wr(3'd3, 8'h00);
        wr(3'd0, 8'h01);
        clk_wait(1);
        chk("retune_busy", busy, 1);
        n = 0;
        while (busy && (n < 20)) begin
            clk_wait(1);
            n++;
        end
        chk("retune_cycles", n, 3);
        chk("tune_acc", acc_inc, 18'h01000);
        chk("tune_tx_en", tx_en, 1);
        chk("tune_audio", audio, 0);

        for (int i = 0; i < 4; i++) begin
            wait_audio(n);
            chk("sample_period", n, 4);
            chk("sb_audio", audio, sb.pop_front());
        end

        // FIFO now empty: next tick underruns.
        wait_audio(n);
        t = cyc;
        chk("urun_period", n, 4);
        chk("urun_audio", audio, 0);
        chk("urun_flag", underrun, 1);
        clk_wait(8);
        chk("urun_sticky", underrun, 1);
        align(t, 2);
        wr(3'd0, 8'h03);
        chk("urun_clear", underrun, 0);
        align(t, 0);
        wr(3'd0, 8'h03);
        chk("urun_set_wins", underrun, 1);

        // Deviation shadow lands only on the next tick.
        align(t, 2);
        wr(3'd4, 8'h0E);
        chk("dev_hold_coef", df_inc_coef, 0);
        chk("dev_hold_fact", df_inc_fact, 0);
        clk_wait(1);
        chk("dev_hold2_coef", df_inc_coef, 0);
        clk_wait(1);
        chk("dev_coef", df_inc_coef, 2);
        chk("dev_fact", df_inc_fact, 3);

        // Ramp up 0x1000 -> 0x10A0 by 0x40 while a sample is playing.
        wr(3'd7, 8'h40);
        wr(3'd1, 8'hA0);
        wr(3'd2, 8'h10);
        push_sb(8'h55);
        expect_sample(t2);
        wr(3'd3, 8'h00);
        chk("commit_busy", busy, 1);
        chk("commit_mute", audio, 0);
        chk("commit_acc", acc_inc, 18'h01000);
        wait_acc(18'h01040, 1'b1);
        wait_acc(18'h01080, 1'b1);
        wait_acc(18'h010A0, 1'b0);
        chk("ramp_up_tx_en", tx_en, 1);

        // Ramp down back to 0x1000.
        wr(3'd1, 8'h00);
        wr(3'd2, 8'h10);
        wr(3'd3, 8'h00);
        chk("down_busy", busy, 1);
        wait_acc(18'h01060, 1'b1);
        wait_acc(18'h01020, 1'b1);
        wait_acc(18'h01000, 1'b0);

        // Disable with two queued samples: they must be flushed.
        push(8'h66);
        push(8'h77);
        wr(3'd0, 8'h00);
        clk_wait(1);
        chk("dis_tx_en", tx_en, 0);
        chk("dis_audio", audio, 0);
        chk("dis_acc", acc_inc, 18'h01000);
        chk("dis_s_ready", s_ready, 1);
        wr(3'd0, 8'h03);
        chk("reen_clear", underrun, 0);
        n = 0;
        while (!underrun && (n < 12)) begin
            clk_wait(1);
            n++;
        end
        chk("flush_urun", underrun, 1);
        chk("flush_audio", audio, 0);
        chk("reen_tx_en", tx_en, 1);

        // Asynchronous reset in the middle of a long ramp.
        wr(3'd1, 8'h00);
        wr(3'd2, 8'h20);
        wr(3'd3, 8'h00);
        clk_wait(2);
        chk("long_busy", busy, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_acc", acc_inc, 0);
        chk("arst_busy", busy, 0);
        chk("arst_tx_en", tx_en, 0);
        chk("arst_underrun", underrun, 0);
        chk("arst_coef", df_inc_coef, 0);
        chk("arst_s_ready", s_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clk_wait(2);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_acc", acc_inc, 0);

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
